alm_mac_digit_serial: RTL and testbench
=======================================

// Module: alm_mac_digit_serial
// PURPOSE
//  Parametrised successor to the 2-bit ALM MAC: signed A_WIDTH x B_WIDTH multiply-accumulate.
//  Iterates over B in 2-bit digits, one digit per cycle, so it maps onto the same 2-bit ALM slice.
//  Adds a valid/ready input handshake, an output strobe, synchronous clear and optional saturation.
//  Sits between the operand-fetch logic and the result collector in the ALM test fabric.
// PARAMETERS
//  A_WIDTH    8   signed multiplicand width (>=2)
//  B_WIDTH    8   signed multiplier width (even, >=2); NDIG = B_WIDTH/2 digits
//  ACC_WIDTH  24  signed accumulator/result width (>= A_WIDTH+B_WIDTH)
//  SATURATE   1   1: clamp accumulate on overflow; 0: two's-complement wrap
// PORTS
//  clk       in   1          clock, all state on rising edge
//  reset_n   in   1          asynchronous reset, active-low
//  in_valid  in   1          operand pair a/b/acc_en valid
//  in_ready  out  1          block can accept an operand pair
//  a         in   A_WIDTH    signed multiplicand
//  b         in   B_WIDTH    signed multiplier
//  acc_en    in   1          1: result += a*b; 0: result = a*b (sampled with a/b)
//  clear     in   1          synchronous: zero the accumulator
//  busy      out  1          operation in flight (state != IDLE)
//  out_valid out  1          one-cycle pulse: result just updated
//  result    out  ACC_WIDTH  signed accumulator value
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, result=0, out_valid=0, product/count/latched operands = 0.
//  Reset mid-operation: the in-flight op is discarded; no out_valid is produced for it.
//  Outputs during reset: in_ready=1 (IDLE), busy=0.
//  FSM:
//   IDLE: in_ready=1. On in_valid: latch a, b, acc_en; product=0; count=0; go to MUL.
//   MUL:  in_ready=0. Each cycle: product += (a*d_k) <<< 2k, with k=count, then count++.
//         After NDIG cycles, go to ACC.
//   ACC:  write result (see below); out_valid=1 on the following cycle; go to IDLE.
//  Digits: d_k = b[2k+1:2k].
//   Unsigned (0..3) for k < NDIG-1.
//   Signed (-2..1) for k = NDIG-1.
//   The product is exact, width A_WIDTH+B_WIDTH, and is sign-extended to ACC_WIDTH.
//  Latency: accept on edge 0; result and out_valid become visible after edge NDIG+1.
//   Default config: NDIG=4, so 5 cycles.
//  Throughput: one op per NDIG+2 cycles.
//  Result write:
//   acc_en=0: result = product.
//   acc_en=1: result = result + product.
//    SATURATE=1: on overflow, clamp to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1).
//    SATURATE=0: wrap.
//  clear:
//   In IDLE or MUL: result <= 0 on the next edge; out_valid is unaffected.
//   In the same cycle as the ACC write: clear wins over accumulate, so result = product.
//  in_valid outside IDLE is ignored: no latch, and the upstream source must hold it.
//  in_valid and clear in IDLE in the same cycle: both take effect.
//  The latched acc_en then adds the product to 0.
//  a, b and acc_en are don't-care while in_valid=0 or in_ready=0.
// STRUCTURE
//  Package alm_mac_pkg:
//   typedef enum logic[1:0] {IDLE, MUL, ACC} mac_state_t;
//   function sat_add(): signed add with clamp, parametrised by width.
//  Sub-module alm_digit_pp: combinational signed a x 2-bit digit partial product.
//   Has a top-digit sign select; one instance.
//  Top level: FSM, digit counter ($clog2(NDIG) bits), product shift-add, accumulator, clear logic.
// TESTING
//  1 Reset: hold reset_n=0 -> result=0, out_valid=0, in_ready=1, busy=0.
//    Release reset -> no spurious out_valid.
//  2 Load: a=-2, b=1, acc_en=0 -> after edge 5, result=-2 with a single out_valid pulse.
//  3 Accumulate, acc_en=1 from reset, ops in order: (-2,1), (-1,0), (0,-2), (1,-1).
//    -> out_valid pulses give result -2, -2, -2, -3.
//  4 Extremes, ACC_WIDTH=16: a=-128, b=-128 twice, acc_en=1.
//    -> first result 16384; second 32767 with SATURATE=1, -32768 with SATURATE=0.
//  5 Handshake: hold in_valid=1 continuously with 3 op pairs.
//    -> in_ready low during MUL/ACC; each op accepted once; exactly 3 out_valid pulses, 6 cycles apart.
//  6 Disruption: reset_n=0 in MUL cycle 2 -> result=0, no out_valid.
//    clear in the ACC cycle with acc_en=1, prior result 50, a=3, b=4 -> result=12.

Source files
------------

// File: rtl/alm_mac_digit_serial_pkg.sv
// alm_mac_pkg: shared FSM state type and clamped adder for the digit-serial MAC.
// sat_add works on a 64-bit carrier; w is the real accumulator width (<= 63).
package alm_mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2
  } mac_state_t;

  localparam int SAT_W = 64;

  typedef logic signed [SAT_W-1:0] wide_t;

  // Operands arrive sign-extended from w bits, so the 64-bit sum is exact.
  function automatic wide_t sat_add(
    input wide_t x,
    input wide_t y,
    input int    w,
    input bit    sat
  );
    wide_t sum;
    wide_t hi;
    wide_t lo;
    wide_t wrap;
    sum  = x + y;
    hi   = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo   = -hi - wide_t'(1);
    wrap = (sum <<< (SAT_W - w)) >>> (SAT_W - w);
    if (!sat)
      return wrap;
    if (sum > hi)
      return hi;
    if (sum < lo)
      return lo;
    return sum;
  endfunction

endpackage

// File: rtl/alm_mac_digit_serial_if.sv
// Operand/result bundle of the digit-serial MAC.
// master: operand source (in_valid,a,b,acc_en,clear); slave: the MAC (in_ready,busy,out_valid,result).
interface alm_mac_digit_serial_if #(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int ACC_WIDTH = 24
);

  logic                        in_valid;
  logic                        in_ready;
  logic signed [A_WIDTH-1:0]   a;
  logic signed [B_WIDTH-1:0]   b;
  logic                        acc_en;
  logic                        clear;
  logic                        busy;
  logic                        out_valid;
  logic signed [ACC_WIDTH-1:0] result;

  modport master (
    output in_valid, a, b, acc_en, clear,
    input  in_ready, busy, out_valid, result
  );

  modport slave (
    input  in_valid, a, b, acc_en, clear,
    output in_ready, busy, out_valid, result
  );

endinterface

// File: rtl/alm_mac_digit_serial_pp.sv
// alm_digit_pp: signed a times one 2-bit digit of b.
// Ports: a (multiplicand), digit, top (1: digit is signed -2..1), pp (exact product).
module alm_digit_pp #(
  parameter int A_WIDTH = 8
) (
  input  logic signed [A_WIDTH-1:0] a,
  input  logic        [1:0]         digit,
  input  logic                      top,
  output logic signed [A_WIDTH+1:0] pp
);

  localparam int PPW = A_WIDTH + 2;

  logic signed [PPW-1:0] a1;
  logic signed [PPW-1:0] a2;

  assign a1 = PPW'(a);
  assign a2 = a1 <<< 1;

  always_comb begin
    pp = '0;
    unique case (1'b1)
      digit == 2'b00:         pp = '0;
      digit == 2'b01:         pp = a1;
      digit == 2'b10 && !top: pp = a2;
      digit == 2'b10 &&  top: pp = -a2;
      digit == 2'b11 && !top: pp = a1 + a2;
      digit == 2'b11 &&  top: pp = -a1;
      default:                pp = '0;
    endcase
  end

endmodule

// File: rtl/alm_mac_digit_serial.sv
// alm_mac_digit_serial: signed MAC iterating b two bits per cycle.
// Ports: clk, reset_n (async, active-low), bus (slave side of the MAC bundle).
module alm_mac_digit_serial #(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int ACC_WIDTH = 24,
  parameter int SATURATE  = 1
) (
  input logic                  clk,
  input logic                  reset_n,
  alm_mac_digit_serial_if.slave bus
);

  import alm_mac_pkg::*;

  localparam int NDIG  = B_WIDTH / 2;
  localparam int PW    = A_WIDTH + B_WIDTH;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  mac_state_t state_q;
  mac_state_t state_d;

  logic signed [A_WIDTH-1:0]   a_q;
  logic        [B_WIDTH-1:0]   b_q;
  logic                        acc_en_q;
  logic signed [PW-1:0]        product_q;
  logic        [CNT_W-1:0]     count_q;
  logic signed [ACC_WIDTH-1:0] result_q;
  logic                        out_valid_q;

  logic                        in_ready;
  logic                        busy;
  logic                        accept;
  logic                        last_dig;
  logic        [1:0]           digit;
  logic signed [A_WIDTH+1:0]   pp;
  logic signed [PW-1:0]        pp_sh;
  wide_t                       sum_w;
  logic signed [ACC_WIDTH-1:0] acc_val;

  assign last_dig = (count_q == CNT_W'(NDIG - 1));

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (bus.in_valid)
          state_d = MUL;
      end
      MUL: begin
        if (last_dig)
          state_d = ACC;
      end
      ACC: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept = in_ready & bus.in_valid;

  assign digit = 2'(b_q >> (2 * count_q));

  alm_digit_pp #(
    .A_WIDTH(A_WIDTH)
  ) u_pp (
    .a    (a_q),
    .digit(digit),
    .top  (last_dig),
    .pp   (pp)
  );

  assign pp_sh = PW'(pp) <<< (2 * count_q);

  assign sum_w = sat_add(wide_t'(result_q), wide_t'(product_q),
                         ACC_WIDTH, SATURATE != 0);

  // A clear coinciding with the write overrides accumulation.
  assign acc_val = (acc_en_q && !bus.clear) ? ACC_WIDTH'(sum_w)
                                            : ACC_WIDTH'(product_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_q == ACC);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_en_q  <= 1'b0;
      product_q <= '0;
      count_q   <= '0;
      result_q  <= '0;
    end else begin
      if (accept) begin
        a_q       <= bus.a;
        b_q       <= bus.b;
        acc_en_q  <= bus.acc_en;
        product_q <= '0;
        count_q   <= '0;
      end
      if (state_q == MUL) begin
        product_q <= product_q + pp_sh;
        count_q   <= count_q + CNT_W'(1);
      end
      if (state_q == ACC)
        result_q <= acc_val;
      else if (bus.clear)
        result_q <= '0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = busy;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_alm_mac_digit_serial.sv
// Bench for alm_mac_digit_serial: default 24-bit DUT plus two 16-bit DUTs
// (saturating and wrapping) driven in lockstep, checked against arithmetic models.
module tb_alm_mac_digit_serial;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic              in_valid = 1'b0;
  logic              acc_en = 1'b0;
  logic              clear = 1'b0;
  logic signed [7:0] a = '0;
  logic signed [7:0] b = '0;

  int checks = 0;
  int failures = 0;

  longint exp24 = 0;
  longint exp16s = 0;
  longint exp16w = 0;

  alm_mac_digit_serial_if #(.A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(24)) m24 ();
  alm_mac_digit_serial_if #(.A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(16)) m16s ();
  alm_mac_digit_serial_if #(.A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(16)) m16w ();

  assign m24.in_valid  = in_valid;
  assign m24.a         = a;
  assign m24.b         = b;
  assign m24.acc_en    = acc_en;
  assign m24.clear     = clear;
  assign m16s.in_valid = in_valid;
  assign m16s.a        = a;
  assign m16s.b        = b;
  assign m16s.acc_en   = acc_en;
  assign m16s.clear    = clear;
  assign m16w.in_valid = in_valid;
  assign m16w.a        = a;
  assign m16w.b        = b;
  assign m16w.acc_en   = acc_en;
  assign m16w.clear    = clear;

  alm_mac_digit_serial #(
    .A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(24), .SATURATE(1)
  ) dut24 (.clk(clk), .reset_n(reset_n), .bus(m24));

  alm_mac_digit_serial #(
    .A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(16), .SATURATE(1)
  ) dut16s (.clk(clk), .reset_n(reset_n), .bus(m16s));

  alm_mac_digit_serial #(
    .A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(16), .SATURATE(0)
  ) dut16w (.clk(clk), .reset_n(reset_n), .bus(m16w));

  function automatic longint fit(longint s, int w, bit sat);
    longint span;
    longint hi;
    longint lo;
    span = longint'(1) <<< w;
    hi = (span / 2) - 1;
    lo = -(span / 2);
    if (sat) begin
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
    end
    return (((s - lo) % span) + span) % span + lo;
  endfunction

  function automatic longint next_val(longint prev, longint prod,
                                      bit acc, bit clr, int w, bit sat);
    if (!acc || clr) return prod;
    return fit(prev + prod, w, sat);
  endfunction

  task automatic model_op(int av, int bv, bit ae, bit clr_idle, bit clr_acc);
    longint prod;
    prod = longint'(av) * longint'(bv);
    if (clr_idle) begin
      exp24 = 0;
      exp16s = 0;
      exp16w = 0;
    end
    exp24  = next_val(exp24, prod, ae, clr_acc, 24, 1'b1);
    exp16s = next_val(exp16s, prod, ae, clr_acc, 16, 1'b1);
    exp16w = next_val(exp16w, prod, ae, clr_acc, 16, 1'b0);
  endtask

  // k counts falling edges after the accepting rising edge.
  task automatic run_op(input int av, input int bv, input bit ae,
                        input bit clr_idle, input int clear_at,
                        output int pulses, output int lat);
    @(negedge clk);
    checks++;
    if (m24.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL op_ready: got %b want 1", m24.in_ready);
    end
    a = 8'(av);
    b = 8'(bv);
    acc_en = ae;
    clear = clr_idle;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    clear = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    acc_en = 1'($urandom);
    pulses = 0;
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (m24.out_valid === 1'b1) begin
        pulses++;
        if (lat < 0) lat = k;
      end
      clear = (k == clear_at);
    end
    clear = 1'b0;
    model_op(av, bv, ae, clr_idle, clear_at >= 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp24 = 0;
    exp16s = 0;
    exp16w = 0;
  endtask

  task automatic test_reset();
    int spur;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (m24.result !== 24'sd0) begin
      failures++;
      $display("FAIL reset_result: got %0d want 0", m24.result);
    end
    checks++;
    if (m24.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid: got %b want 0", m24.out_valid);
    end
    checks++;
    if (m24.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", m24.in_ready);
    end
    checks++;
    if (m24.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b want 0", m24.busy);
    end
    reset_n = 1'b1;
    spur = 0;
    repeat (5) begin
      @(negedge clk);
      if (m24.out_valid !== 1'b0) spur++;
    end
    checks++;
    if (spur != 0) begin
      failures++;
      $display("FAIL reset_spurious: got %0d pulses want 0", spur);
    end
  endtask

  task automatic test_load();
    int p;
    int l;
    run_op(-2, 1, 1'b0, 1'b0, -1, p, l);
    checks++;
    if (m24.result !== 24'(-2)) begin
      failures++;
      $display("FAIL load_result: got %0d want -2", m24.result);
    end
    checks++;
    if (p != 1) begin
      failures++;
      $display("FAIL load_pulses: got %0d want 1", p);
    end
    checks++;
    if (l != 5) begin
      failures++;
      $display("FAIL load_latency: got %0d want 5", l);
    end
  endtask

  task automatic test_accumulate();
    int ta [4] = '{-2, -1, 0, 1};
    int tb [4] = '{1, 0, -2, -1};
    int te [4] = '{-2, -2, -2, -3};
    int p;
    int l;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], 1'b1, 1'b0, -1, p, l);
      checks++;
      if (m24.result !== 24'(te[i]) || p != 1) begin
        failures++;
        $display("FAIL accum_%0d: got %0d (%0d pulses) want %0d (1 pulse)",
                 i, m24.result, p, te[i]);
      end
    end
  endtask

  task automatic test_extremes();
    int es [2] = '{16384, 32767};
    int ew [2] = '{16384, -32768};
    int p;
    int l;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    exp24 = 0;
    exp16s = 0;
    exp16w = 0;
    for (int i = 0; i < 2; i++) begin
      run_op(-128, -128, 1'b1, 1'b0, -1, p, l);
      checks++;
      if (m16s.result !== 16'(es[i])) begin
        failures++;
        $display("FAIL extreme_sat_%0d: got %0d want %0d", i, m16s.result, es[i]);
      end
      checks++;
      if (m16w.result !== 16'(ew[i])) begin
        failures++;
        $display("FAIL extreme_wrap_%0d: got %0d want %0d", i, m16w.result, ew[i]);
      end
      checks++;
      if (m24.result !== exp24) begin
        failures++;
        $display("FAIL extreme_24_%0d: got %0d want %0d", i, m24.result, exp24);
      end
    end
  endtask

  task automatic test_random();
    int av;
    int bv;
    bit ae;
    bit ci;
    int p;
    int l;
    for (int i = 0; i < 24; i++) begin
      av = int'($urandom_range(255)) - 128;
      bv = int'($urandom_range(255)) - 128;
      ae = ($urandom_range(3) != 0);
      ci = ($urandom_range(5) == 0);
      run_op(av, bv, ae, ci, -1, p, l);
      checks++;
      if (m24.result !== exp24 || p != 1) begin
        failures++;
        $display("FAIL rand24_%0d: got %0d (%0d pulses) want %0d", i, m24.result, p, exp24);
      end
      checks++;
      if (m16s.result !== exp16s) begin
        failures++;
        $display("FAIL rand16s_%0d: got %0d want %0d", i, m16s.result, exp16s);
      end
      checks++;
      if (m16w.result !== exp16w) begin
        failures++;
        $display("FAIL rand16w_%0d: got %0d want %0d", i, m16w.result, exp16w);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ia [3];
    int ib [3];
    bit ie [3];
    longint q24 [$];
    longint want;
    int idx;
    int pulses;
    int last_t;
    int gap_bad;
    int bad_ready;
    bit acc_now;
    for (int i = 0; i < 3; i++) begin
      ia[i] = int'($urandom_range(255)) - 128;
      ib[i] = int'($urandom_range(255)) - 128;
      ie[i] = 1'($urandom);
      model_op(ia[i], ib[i], ie[i], 1'b0, 1'b0);
      q24.push_back(exp24);
    end
    idx = 0;
    pulses = 0;
    last_t = -1;
    gap_bad = 0;
    bad_ready = 0;
    @(negedge clk);
    a = 8'(ia[0]);
    b = 8'(ib[0]);
    acc_en = ie[0];
    in_valid = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (m24.busy === 1'b1 && m24.in_ready !== 1'b0) bad_ready++;
      if (m24.out_valid === 1'b1) begin
        pulses++;
        want = (q24.size() > 0) ? q24.pop_front() : 0;
        checks++;
        if (m24.result !== want) begin
          failures++;
          $display("FAIL b2b_result_%0d: got %0d want %0d", pulses, m24.result, want);
        end
        if (last_t >= 0 && t - last_t != 6) gap_bad++;
        last_t = t;
      end
      acc_now = in_valid && (m24.in_ready === 1'b1);
      @(negedge clk);
      if (acc_now) begin
        idx++;
        if (idx < 3) begin
          a = 8'(ia[idx]);
          b = 8'(ib[idx]);
          acc_en = ie[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (pulses != 3 || idx != 3) begin
      failures++;
      $display("FAIL b2b_count: got %0d pulses %0d accepts want 3 3", pulses, idx);
    end
    checks++;
    if (gap_bad != 0) begin
      failures++;
      $display("FAIL b2b_spacing: got %0d bad gaps want 0", gap_bad);
    end
    checks++;
    if (bad_ready != 0) begin
      failures++;
      $display("FAIL b2b_ready: got %0d busy cycles with in_ready want 0", bad_ready);
    end
  endtask

  task automatic test_disruption();
    int spur;
    int p;
    int l;
    @(negedge clk);
    a = 8'sd3;
    b = 8'sd5;
    acc_en = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (m24.result !== 24'sd0 || m24.out_valid !== 1'b0 || m24.busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state: got result %0d ov %b busy %b want 0 0 0",
               m24.result, m24.out_valid, m24.busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp24 = 0;
    exp16s = 0;
    exp16w = 0;
    spur = 0;
    repeat (8) begin
      @(negedge clk);
      if (m24.out_valid !== 1'b0) spur++;
    end
    checks++;
    if (spur != 0 || m24.result !== 24'sd0) begin
      failures++;
      $display("FAIL midreset_after: got %0d pulses result %0d want 0 0", spur, m24.result);
    end
    run_op(5, 10, 1'b0, 1'b0, -1, p, l);
    checks++;
    if (m24.result !== 24'sd50) begin
      failures++;
      $display("FAIL clear_pre: got %0d want 50", m24.result);
    end
    run_op(3, 4, 1'b1, 1'b0, 4, p, l);
    checks++;
    if (m24.result !== 24'sd12 || m24.result !== exp24 || p != 1) begin
      failures++;
      $display("FAIL clear_in_acc: got %0d (%0d pulses) want 12", m24.result, p);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load();
    test_accumulate();
    test_extremes();
    test_random();
    test_back_to_back();
    test_disruption();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
